nios_debug_scan_master: RTL and testbench
=========================================

// Module: nios_debug_scan_master
// PURPOSE
// - Initiator side of the Nios II virtual-JTAG debug scan interface.
// - Per command, drives the IR/DR scan sequence into the CPU debug slave:
//   UIR (ir_in) -> CDR -> SDR (shift DR_WIDTH bits) -> UDR -> RTI.
// - Captures tdo during the shift and returns it as a response.
// - Used to exercise the debug slave from on-chip logic and in simulation, without an sld hub.
// PARAMETERS
// - DR_WIDTH  38  data register length, in bits.
// - IR_WIDTH  2   virtual IR width.
// - TCK_DIV   2   tck half-period, in clk cycles; must be >=1.
// PORTS
// - clk          in   1         system clock; all logic on rising edge.
// - reset        in   1         synchronous, active-high reset.
// - cmd_valid    in   1         command offered.
// - cmd_ready    out  1         command accepted when cmd_valid&&cmd_ready.
// - cmd_ir       in   IR_WIDTH  virtual IR value for this scan.
// - cmd_ir_only  in   1         1 = skip CDR/SDR/UDR (IR update only).
// - cmd_data     in   DR_WIDTH  DR value to shift in, LSB first.
// - rsp_valid    out  1         response available.
// - rsp_ready    in   1         response consumed when rsp_valid&&rsp_ready.
// - rsp_data     out  DR_WIDTH  captured tdo bits (bit0 = first captured).
// - rsp_ir_out   out  IR_WIDTH  ir_out sampled during UIR.
// - tck          out  1         generated scan clock.
// - tdi          out  1         serial data to the slave.
// - tdo          in   1         serial data from the slave.
// - ir_in        out  IR_WIDTH  virtual IR to the slave.
// - ir_out       in   IR_WIDTH  IR status from the slave.
// - vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti   out  1 each
//   virtual state strobes.
// BEHAVIOUR
// - Reset: state IDLE.
//   - All outputs 0, including cmd_ready; cmd_ready goes to 1 the cycle after reset deasserts.
//   - Reset mid-scan aborts immediately: no response, strobes/tck drop to 0 on the next edge.
// - States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
// - cmd_ready = (state==IDLE). On accept:
//   - latch cmd_ir, cmd_data, cmd_ir_only;
//   - next state UIR.
// - Every non-IDLE/RESP state lasts whole tck periods of 2*TCK_DIV clk cycles.
//   - tck is low for the first TCK_DIV cycles of a period, high for the next TCK_DIV.
//   - tck is 0 in IDLE and RESP.
//   - State strobes, ir_in and tdi change only at period boundaries (tck falling edge).
//   - Inputs are sampled on the clk edge where tck rises.
// - UIR: 1 period.
//   - vs_uir=1; ir_in=latched ir.
//   - ir_out sampled into rsp_ir_out.
//   - Next: CDR, or RTI if ir_only.
// - ir_in holds its value until the next accepted command.
// - CDR: 1 period; vs_cdr=1.
// - SDR: DR_WIDTH periods; vs_sdr=1.
//   - tdi = shreg[0].
//   - At each tck rise: shreg <= {tdo, shreg[DR_WIDTH-1:1]}.
//   - A bit counter ends SDR after exactly DR_WIDTH shifts; no wrap or extra shift.
// - UDR: 1 period; vs_udr=1.
// - RTI: 1 period; jtag_state_rti=1.
// - RESP: rsp_valid=1; rsp_data=shreg (ir_only: rsp_data=cmd_data unchanged).
//   - rsp_data/rsp_ir_out are held stable until the handshake.
//   - On rsp_ready -> IDLE; cmd_ready=1 the following cycle.
//   - No command is accepted the same cycle a response leaves.
// - Latency: accept at edge 0; rsp_valid rises at edge 1+N*2*TCK_DIV.
//   - Full scan: N = DR_WIDTH+4.
//   - ir_only: N = 2.
//   - Defaults (full scan): edge 169.
// - rsp_valid stays high indefinitely while rsp_ready=0; no further scan starts.
// - Exactly one strobe is high per period; no strobes are high in IDLE/RESP.
// TESTING
// - T1 loopback (tdo=tdi), ir=2'b01, data=38'h2A_5555_5555, defaults.
//   -> rsp_data==38'h2A_5555_5555; rsp_valid at edge 169.
//   -> Exactly 38 vs_sdr periods; exactly 42 tck rises.
// - T2 tdo tied 1, data=0 -> rsp_data==38'h3F_FFFF_FFFF.
//   - Bench checks that tdi bit k equals data[k] during the k-th SDR period.
// - T3 cmd_ir_only=1, ir=2'b11, ir_out tied 2'b10.
//   -> No vs_cdr/vs_sdr/vs_udr; rsp_ir_out==2'b10; rsp_valid at edge 9.
// - T4 rsp_ready low for 20 cycles, cmd_valid held high.
//   -> rsp_valid and rsp_data stable for the 20 cycles.
//   -> Second command accepted exactly 1 cycle after the rsp handshake.
// - T5 reset pulse at 10th SDR period.
//   -> Next cycle all strobes, tck and rsp_valid are 0.
//   -> cmd_ready=1 after release; a new scan completes correctly.
// - T6 TCK_DIV=1, loopback, data=38'h01_0000_0001.
//   -> rsp_data unchanged; rsp_valid at edge 85.

Source files
------------

// File: rtl/nios_debug_scan_master_if.sv
// Command/response handshake plus virtual-JTAG scan bus of the Nios II debug scan master.
// The scan master uses the master modport; the command source and debug slave use the slave modport.
interface nios_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic                cmd_ir_only;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic [IR_WIDTH-1:0] ir_out;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_udr;
  logic                jtag_state_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_ir_only, cmd_data, rsp_ready, tdo, ir_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_ir_only, cmd_data, rsp_ready, tdo, ir_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/nios_debug_scan_master.sv
// Nios II virtual-JTAG scan initiator: per command runs UIR -> CDR -> SDR -> UDR -> RTI
// with a divided tck, captures tdo during SDR and returns it as a response.
module nios_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_debug_scan_master_if.master bus
);
  localparam int PERIOD = 2 * TCK_DIV;
  localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CNT_W  = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shreg;
  logic                ir_only;
  logic                tdi_q;
  logic                ready_en;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_out_q;
  logic                rsp_valid_q;

  logic scanning;
  logic period_end;
  logic tck_rise;
  logic accept;
  logic rsp_fire;

  assign scanning   = (state != IDLE) && (state != RESP);
  assign period_end = scanning && (div_cnt == DIV_W'(PERIOD - 1));
  assign tck_rise   = scanning && (div_cnt == DIV_W'(TCK_DIV - 1));
  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire   = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)     state_next = UIR;
      UIR:  if (period_end) state_next = ir_only ? RTI : CDR;
      CDR:  if (period_end) state_next = SDR;
      SDR:  if (period_end && (bit_cnt == CNT_W'(DR_WIDTH))) state_next = UDR;
      UDR:  if (period_end) state_next = RTI;
      RTI:  if (period_end) state_next = RESP;
      RESP: if (rsp_fire)   state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // tdi is reloaded only at period boundaries; the shift at tck rise has already exposed the next bit
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ir_only     <= 1'b0;
      tdi_q       <= 1'b0;
      ready_en    <= 1'b0;
      ir_q        <= '0;
      ir_out_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      div_cnt     <= (period_end || !scanning) ? '0 : div_cnt + 1'b1;
      rsp_valid_q <= (state == RESP) && !rsp_fire;
      if (accept) begin
        ir_q    <= bus.cmd_ir;
        shreg   <= bus.cmd_data;
        ir_only <= bus.cmd_ir_only;
        bit_cnt <= '0;
      end
      if ((state == UIR) && tck_rise) begin
        ir_out_q <= bus.ir_out;
      end
      if ((state == SDR) && tck_rise) begin
        shreg   <= {bus.tdo, shreg[DR_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (period_end) begin
        tdi_q <= (state_next == SDR) ? shreg[0] : 1'b0;
      end
    end
  end

  assign bus.cmd_ready      = (state == IDLE) && ready_en;
  assign bus.tck            = scanning && (div_cnt >= DIV_W'(TCK_DIV));
  assign bus.tdi            = tdi_q;
  assign bus.ir_in          = ir_q;
  assign bus.vs_uir         = (state == UIR);
  assign bus.vs_cdr         = (state == CDR);
  assign bus.vs_sdr         = (state == SDR);
  assign bus.vs_udr         = (state == UDR);
  assign bus.jtag_state_rti = (state == RTI);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = shreg;
  assign bus.rsp_ir_out     = ir_out_q;
endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Bench for nios_debug_scan_master: a scan-schedule model checks every cycle, directed tests pin latencies and data.
module tb_nios_debug_scan_master;
  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int DIV = 2;
  localparam int P   = 2 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nios_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IRW)) bus ();
  nios_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IRW)) bus_f ();

  nios_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  nios_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(1)) dut_f (
    .clk(clk), .reset(reset), .bus(bus_f)
  );

  logic loopback;
  logic tdo_level;
  assign bus.tdo   = loopback ? bus.tdi : tdo_level;
  assign bus_f.tdo = bus_f.tdi;

  int total = 0;
  int bad   = 0;

  // model of the main DUT, updated at each rising edge
  int              cyc = 0;
  bit              active = 1'b0;
  bit              ready_ok = 1'b0;
  bit              m_ir_only;
  int              acc_cyc = -1;
  int              m_periods;
  logic [DR-1:0]   m_data;
  logic [DR-1:0]   m_rsp;
  logic [IRW-1:0]  m_ir_in = '0;
  logic [IRW-1:0]  m_irout_exp;

  int   tck_rises = 0;
  int   sdr_periods = 0;
  int   cdr_cycles = 0;
  int   udr_cycles = 0;
  logic tck_prev = 1'b0;

  int a_edge, r_edge, hs_edge;
  int s_tck, s_sdr, s_cdr, s_udr;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic logic [4:0] strobesOf(input int p, input bit ir_only);
    int kind;
    if (ir_only)           kind = (p == 0) ? 1 : 5;
    else if (p == 0)       kind = 1;
    else if (p == 1)       kind = 2;
    else if (p < DR + 2)   kind = 3;
    else if (p == DR + 2)  kind = 4;
    else                   kind = 5;
    return 5'b10000 >> (kind - 1);
  endfunction

  task automatic applyStimulus(input bit fast, input logic [IRW-1:0] ir, input logic [DR-1:0] data,
                               input bit ir_only, output int acc_edge);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fast ? bus_f.cmd_ready : bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("cmd_ready_timeout", 64'd0, 64'd1);
    if (fast) begin
      bus_f.cmd_valid = 1'b1; bus_f.cmd_ir = ir; bus_f.cmd_data = data; bus_f.cmd_ir_only = ir_only;
    end else begin
      bus.cmd_valid = 1'b1; bus.cmd_ir = ir; bus.cmd_data = data; bus.cmd_ir_only = ir_only;
    end
    @(posedge clk);
    #1;
    acc_edge = cyc;
    bus.cmd_valid = 1'b0;
    bus_f.cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(input bit fast, output int rsp_edge);
    rsp_edge = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fast ? bus_f.rsp_valid : bus.rsp_valid) begin
        rsp_edge = cyc;
        break;
      end
    end
    if (rsp_edge < 0) checkOutput("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic consumeResponse(input bit fast, output int hs);
    if (fast) bus_f.rsp_ready = 1'b1; else bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    bus.rsp_ready = 1'b0;
    bus_f.rsp_ready = 1'b0;
  endtask

  initial begin
    loopback = 1'b1; tdo_level = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_ir_only = 1'b0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0; bus.ir_out = '0;
    bus_f.cmd_valid = 1'b0; bus_f.cmd_ir = '0; bus_f.cmd_ir_only = 1'b0; bus_f.cmd_data = '0;
    bus_f.rsp_ready = 1'b0; bus_f.ir_out = '0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
          active = 1'b0; ready_ok = 1'b0; m_ir_in = '0;
        end else begin
          if (active && bus.rsp_valid && bus.rsp_ready) begin
            active = 1'b0;
          end else if (!active && bus.cmd_valid && bus.cmd_ready) begin
            active      = 1'b1;
            acc_cyc     = cyc;
            m_ir_only   = bus.cmd_ir_only;
            m_data      = bus.cmd_data;
            m_ir_in     = bus.cmd_ir;
            m_irout_exp = bus.ir_out;
            m_periods   = m_ir_only ? 2 : DR + 4;
            if (m_ir_only)     m_rsp = m_data;
            else if (loopback) m_rsp = m_data;
            else               m_rsp = {DR{tdo_level}};
          end
          ready_ok = 1'b1;
        end
      end
      forever begin : checker_loop
        int t, p, ph, span;
        logic [4:0] sb;
        @(negedge clk);
        if (cyc > 0) begin
          sb = {bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr, bus.jtag_state_rti};
          checkOutput("ir_in", bus.ir_in, m_ir_in);
          if (active) begin
            t = cyc - acc_cyc;
            span = m_periods * P;
            checkOutput("cmd_ready_busy", bus.cmd_ready, 0);
            if (t < span) begin
              p  = t / P;
              ph = t % P;
              checkOutput("tck", bus.tck, (ph >= DIV) ? 1 : 0);
              checkOutput("strobes", sb, strobesOf(p, m_ir_only));
              checkOutput("rsp_valid_scan", bus.rsp_valid, 0);
              if (!m_ir_only && p >= 2 && p < DR + 2)
                checkOutput("tdi_bit", bus.tdi, m_data[p-2]);
            end else begin
              checkOutput("tck_resp", bus.tck, 0);
              checkOutput("strobes_resp", sb, 0);
              checkOutput("rsp_valid_resp", bus.rsp_valid, (t > span) ? 1 : 0);
              if (t > span) begin
                checkOutput("rsp_data", bus.rsp_data, m_rsp);
                checkOutput("rsp_ir_out", bus.rsp_ir_out, m_irout_exp);
              end
            end
          end else begin
            checkOutput("cmd_ready_idle", bus.cmd_ready, ready_ok);
            checkOutput("tck_idle", bus.tck, 0);
            checkOutput("strobes_idle", sb, 0);
            checkOutput("rsp_valid_idle", bus.rsp_valid, 0);
          end
        end
      end
      forever begin
        @(negedge clk);
        if (bus.tck && !tck_prev) begin
          tck_rises++;
          if (bus.vs_sdr) sdr_periods++;
        end
        tck_prev = bus.tck;
        if (bus.vs_cdr) cdr_cycles++;
        if (bus.vs_udr) udr_cycles++;
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_tck", bus.tck, 0);
    checkOutput("rst_ir_in", bus.ir_in, 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_rst", bus.cmd_ready, 1);

    $display("[TB] T1 loopback full scan");
    s_tck = tck_rises; s_sdr = sdr_periods;
    applyStimulus(0, 2'b01, 38'h2A_5555_5555, 0, a_edge);
    waitResponse(0, r_edge);
    checkOutput("t1_latency", r_edge - a_edge, 169);
    checkOutput("t1_data", bus.rsp_data, 38'h2A_5555_5555);
    consumeResponse(0, hs_edge);
    checkOutput("t1_sdr_periods", sdr_periods - s_sdr, 38);
    checkOutput("t1_tck_rises", tck_rises - s_tck, 42);

    $display("[TB] T2 tdo tied high");
    loopback = 1'b0; tdo_level = 1'b1;
    applyStimulus(0, 2'b10, 38'h0, 0, a_edge);
    waitResponse(0, r_edge);
    checkOutput("t2_data", bus.rsp_data, 38'h3F_FFFF_FFFF);
    consumeResponse(0, hs_edge);

    $display("[TB] T3 IR-only scan");
    loopback = 1'b1; bus.ir_out = 2'b10;
    s_tck = tck_rises; s_sdr = sdr_periods; s_cdr = cdr_cycles; s_udr = udr_cycles;
    applyStimulus(0, 2'b11, 38'h12_3456_789A, 1, a_edge);
    waitResponse(0, r_edge);
    checkOutput("t3_latency", r_edge - a_edge, 9);
    checkOutput("t3_ir_out", bus.rsp_ir_out, 2'b10);
    checkOutput("t3_data", bus.rsp_data, 38'h12_3456_789A);
    checkOutput("t3_ir_in", bus.ir_in, 2'b11);
    consumeResponse(0, hs_edge);
    checkOutput("t3_no_cdr", cdr_cycles - s_cdr, 0);
    checkOutput("t3_no_udr", udr_cycles - s_udr, 0);
    checkOutput("t3_no_sdr", sdr_periods - s_sdr, 0);
    checkOutput("t3_tck_rises", tck_rises - s_tck, 2);

    $display("[TB] T4 response backpressure");
    applyStimulus(0, 2'b01, 38'h0F_0F0F_0F0F, 0, a_edge);
    bus.cmd_valid = 1'b1; bus.cmd_ir = 2'b10; bus.cmd_data = 38'h30_F0F0_F0F0; bus.cmd_ir_only = 1'b0;
    waitResponse(0, r_edge);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", bus.rsp_valid, 1);
      checkOutput("t4_hold_data", bus.rsp_data, 38'h0F_0F0F_0F0F);
    end
    consumeResponse(0, hs_edge);
    @(posedge clk);
    #1;
    checkOutput("t4_next_accept", acc_cyc - hs_edge, 1);
    a_edge = acc_cyc;
    bus.cmd_valid = 1'b0;
    waitResponse(0, r_edge);
    checkOutput("t4_latency2", r_edge - a_edge, 169);
    checkOutput("t4_data2", bus.rsp_data, 38'h30_F0F0_F0F0);
    consumeResponse(0, hs_edge);

    $display("[TB] T5 reset mid-SDR");
    applyStimulus(0, 2'b01, 38'h3A_BCDE_F012, 0, a_edge);
    repeat (44) @(posedge clk);
    #1;
    checkOutput("t5_in_sdr", bus.vs_sdr, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t5_tck", bus.tck, 0);
    checkOutput("t5_strobes", {bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr, bus.jtag_state_rti}, 0);
    checkOutput("t5_rsp_valid", bus.rsp_valid, 0);
    checkOutput("t5_cmd_ready_rst", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("t5_cmd_ready", bus.cmd_ready, 1);
    applyStimulus(0, 2'b10, 38'h15_A5A5_0F0F, 0, a_edge);
    waitResponse(0, r_edge);
    checkOutput("t5_latency", r_edge - a_edge, 169);
    checkOutput("t5_data", bus.rsp_data, 38'h15_A5A5_0F0F);
    consumeResponse(0, hs_edge);

    $display("[TB] T6 TCK_DIV=1 loopback");
    applyStimulus(1, 2'b01, 38'h01_0000_0001, 0, a_edge);
    waitResponse(1, r_edge);
    checkOutput("t6_latency", r_edge - a_edge, 85);
    checkOutput("t6_data", bus_f.rsp_data, 38'h01_0000_0001);
    consumeResponse(1, hs_edge);
    @(negedge clk);
    checkOutput("t6_rsp_dropped", bus_f.rsp_valid, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
